// File: rtl/arch_ctrl.sv
// arch_ctrl: phase sequencer driving forward/backward enables and completion pulses
// for the two-layer network datapath.
module arch_ctrl #(
  parameter int L_FPH = 8,
  parameter int L_FPO = 32,
  parameter int L_BPO = 4,
  parameter int L_BPH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic TR,
  input  logic VL,
  input  logic END,
  output logic FPH,
  output logic FPO,
  output logic BPO,
  output logic BPH,
  output logic S_Train,
  output logic S_Error
);
  localparam int LMAX_A = (L_FPH > L_FPO) ? L_FPH : L_FPO;
  localparam int LMAX_B = (L_BPO > L_BPH) ? L_BPO : L_BPH;
  localparam int LMAX   = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int CW     = (LMAX > 1) ? $clog2(LMAX) : 1;
  typedef enum logic [2:0] {IDLE, S_FPH, S_FPO, S_BPO, S_BPH, S_TRN, S_ERR, DONE} state_t;
  state_t state_q, state_d;
  logic train_q, train_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] flags_q, flags_d;
  logic phase, phase_end;
  assign phase = (state_q == S_FPH) || (state_q == S_FPO) || (state_q == S_BPO) || (state_q == S_BPH);
  assign phase_end = (state_q == S_FPH) ? (cnt_q == CW'(L_FPH - 1)) :
                     (state_q == S_FPO) ? (cnt_q == CW'(L_FPO - 1)) :
                     (state_q == S_BPO) ? (cnt_q == CW'(L_BPO - 1)) :
                     (state_q == S_BPH) ? (cnt_q == CW'(L_BPH - 1)) : 1'b0;
  always_comb begin
    state_d = state_q;
    train_d = train_q;
    if (END && state_q != DONE) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (TR) begin
            state_d = S_FPH;
            train_d = 1'b1;
          end else if (VL) begin
            state_d = S_FPH;
            train_d = 1'b0;
          end
        end
        S_FPH:   state_d = phase_end ? S_FPO : S_FPH;
        S_FPO:   state_d = phase_end ? (train_q ? S_BPO : S_ERR) : S_FPO;
        S_BPO:   state_d = phase_end ? S_BPH : S_BPO;
        S_BPH:   state_d = phase_end ? S_TRN : S_BPH;
        S_TRN:   state_d = IDLE;
        S_ERR:   state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    cnt_d = (state_d != state_q) ? '0 : (phase ? cnt_q + CW'(1) : cnt_q);
    flags_d = {state_d == S_FPH, state_d == S_FPO, state_d == S_BPO,
               state_d == S_BPH, state_d == S_TRN, state_d == S_ERR};
  end
  // Flags are registered from the next state so they track state_q cycle-exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      train_q <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end
  assign {FPH, FPO, BPO, BPH, S_Train, S_Error} = flags_q;
endmodule

// File: tb/tb_arch_ctrl.sv
// tb_arch_ctrl: checks a default and an all-ones instance of arch_ctrl against an
// offset-based reference of the phase schedule.
module tb_arch_ctrl;
  logic clk, rst_n, TR, VL, END;
  logic fph0, fpo0, bpo0, bph0, trn0, err0;
  logic fph1, fpo1, bpo1, bph1, trn1, err1;
  int checks = 0;
  int failures = 0;
  int e = 0;
  int lp [2][4] = '{'{8, 32, 4, 4}, '{1, 1, 1, 1}};
  bit busy [2] = '{0, 0};
  bit done [2] = '{0, 0};
  bit trn  [2] = '{0, 0};
  int s    [2] = '{0, 0};

  arch_ctrl u0 (.clk(clk), .rst_n(rst_n), .TR(TR), .VL(VL), .END(END),
    .FPH(fph0), .FPO(fpo0), .BPO(bpo0), .BPH(bph0), .S_Train(trn0), .S_Error(err0));
  arch_ctrl #(.L_FPH(1), .L_FPO(1), .L_BPO(1), .L_BPH(1)) u1 (.clk(clk), .rst_n(rst_n),
    .TR(TR), .VL(VL), .END(END),
    .FPH(fph1), .FPO(fpo1), .BPO(bpo1), .BPH(bph1), .S_Train(trn1), .S_Error(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int plen(int i);
    return lp[i][0] + lp[i][1] + (trn[i] ? lp[i][2] + lp[i][3] : 0) + 1;
  endfunction

  // Expected {FPH,FPO,BPO,BPH,S_Train,S_Error} from the cycle offset k within a pass.
  function automatic logic [5:0] expv(int i);
    int k, a, b, c, d;
    if (done[i] || !busy[i]) return 6'b000000;
    k = e - s[i] + 1;
    a = lp[i][0];
    b = a + lp[i][1];
    c = b + lp[i][2];
    d = c + lp[i][3];
    if (k <= a) return 6'b100000;
    if (k <= b) return 6'b010000;
    if (!trn[i]) return 6'b000001;
    if (k <= c) return 6'b001000;
    if (k <= d) return 6'b000100;
    return 6'b000010;
  endfunction

  task automatic mdl_edge(int i, logic tr, logic vl, logic en);
    if (done[i]) return;
    if (en) begin
      done[i] = 1;
      busy[i] = 0;
    end else if (busy[i]) begin
      if (e - s[i] == plen(i)) busy[i] = 0;
    end else if (tr || vl) begin
      busy[i] = 1;
      s[i] = e;
      trn[i] = tr;
    end
  endtask

  task automatic check();
    logic [5:0] obs, exp_v;
    for (int i = 0; i < 2; i++) begin
      obs = (i == 0) ? {fph0, fpo0, bpo0, bph0, trn0, err0} : {fph1, fpo1, bpo1, bph1, trn1, err1};
      exp_v = expv(i);
      checks++;
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL flags u%0d cyc=%0d observed=%b expected=%b", i, e, obs, exp_v);
      end
      checks++;
      assert ($onehot0(obs) === 1'b1) else begin
        failures++;
        $error("FAIL onehot0 u%0d cyc=%0d observed=%b expected=at most one bit", i, e, obs);
      end
    end
  endtask

  task automatic step(logic tr, logic vl, logic en);
    TR = tr;
    VL = vl;
    END = en;
    @(posedge clk);
    e++;
    for (int i = 0; i < 2; i++) mdl_edge(i, tr, vl, en);
    #1;
    check();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0;
      done[i] = 0;
    end
    check();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    TR = 1'b0;
    VL = 1'b0;
    END = 1'b0;
    #2 check();
    #1 rst_n = 1'b1;
    // training with defaults
    step(1, 0, 0);
    repeat (55) step(0, 0, 0);
    // validation
    step(0, 1, 0);
    repeat (45) step(0, 0, 0);
    // TR and VL together select training
    step(1, 1, 0);
    repeat (52) step(0, 0, 0);
    // held TR: back-to-back passes
    repeat (120) step(1, 0, 0);
    repeat (55) step(0, 0, 0);
    // randomized TR/VL, including toggles during passes
    repeat (400) step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 0);
    repeat (55) step(0, 0, 0);
    // asynchronous reset during FPO, then a validation pulse
    step(1, 0, 0);
    repeat (15) step(0, 0, 0);
    checks++;
    assert (fpo0 === 1'b1) else begin
      failures++;
      $error("FAIL fpo_before_reset observed=%b expected=1", fpo0);
    end
    do_reset();
    step(0, 1, 0);
    checks++;
    assert (fph0 === 1'b1) else begin
      failures++;
      $error("FAIL fph_after_reset observed=%b expected=1", fph0);
    end
    repeat (45) step(0, 0, 0);
    // abort during BPO, later requests ignored
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    checks++;
    assert (bpo0 === 1'b1) else begin
      failures++;
      $error("FAIL bpo_before_abort observed=%b expected=1", bpo0);
    end
    step(0, 0, 1);
    repeat (5) begin
      step(1, 0, 0);
      step(0, 1, 0);
    end
    repeat (60) step(0, 0, 0);
    // all-ones parameters: S_Train five cycles after the sampling edge
    do_reset();
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    checks++;
    assert (trn1 === 1'b1) else begin
      failures++;
      $error("FAIL sweep_strain observed=%b expected=1", trn1);
    end
    repeat (10) step(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arch_ctrl.md
# arch_ctrl

- Phase sequencer for the two-layer network datapath (hidden ReLU layer plus sigmoid output neuron).
- Runs a training pass as four phases: hidden forward, output forward, output backward, hidden backward. The `S_Train` pulse then commits the weights.
- Runs a validation pass as the two forward phases only, then an `S_Error` pulse.
- Sits between the pattern/top-level controller (`TR`/`VL`/`END`) and the neuron arrays (`FPH`/`FPO`/`BPO`/`BPH`).

## Interface
- `L_FPH`, default 8: cycles `FPH` is held (hidden forward).
- `L_FPO`, default 32: cycles `FPO` is held (output forward).
- `L_BPO`, default 4: cycles `BPO` is held (output backward).
- `L_BPH`, default 4: cycles `BPH` is held (hidden backward).
- All `L_*` values are ≥1. The counter width is `$clog2` of the largest value.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `TR` in 1: training request.
- `VL` in 1: validation request.
- `END` in 1: process complete, stop sequencing.
- `FPH` out 1: hidden-layer forward enable.
- `FPO` out 1: output-neuron forward enable.
- `BPO` out 1: output-neuron backward enable.
- `BPH` out 1: hidden-layer backward enable.
- `S_Train` out 1: training pattern complete; weights latch on this.
- `S_Error` out 1: validation pattern complete.

## Operation
- States: IDLE, S_FPH, S_FPO, S_BPO, S_BPH, S_TRN, S_ERR, DONE.
- Outputs are registered Moore decodes and one-hot-or-zero:
  - `FPH` only in S_FPH, `FPO` only in S_FPO, `BPO` only in S_BPO, `BPH` only in S_BPH.
  - `S_Train` only in S_TRN; `S_Error` only in S_ERR.
  - IDLE and DONE drive all outputs 0.
- IDLE transitions, in priority order `END` > `TR` > `VL`:
  - `END`=1 → DONE.
  - else `TR`=1 → S_FPH, mode latched = train.
  - else `VL`=1 → S_FPH, mode latched = validate.
  - else stay.
- Sequence:
  - S_FPH (L_FPH cycles) → S_FPO (L_FPO cycles).
  - Then mode train → S_BPO (L_BPO) → S_BPH (L_BPH) → S_TRN (1 cycle) → IDLE.
  - Or mode validate → S_ERR (1 cycle) → IDLE.
- The output backward phase precedes the hidden backward phase, because the hidden layer consumes the output neuron's dZ.
- Phase counter: reloaded to 0 on every state entry. A phase state exits when count = L_x−1.
- `TR`/`VL` are sampled only in IDLE. Changes during a pass are ignored, and the latched mode holds to the end of the pass.
- `END` asserted in any non-DONE state aborts at the next edge: go to DONE, all outputs 0, no completion pulse.
- DONE is absorbing until `rst_n` is asserted.
- If `TR` or `VL` is still high when the FSM returns to IDLE, the next pass starts after exactly one IDLE cycle.

## Timing
- Reset (`rst_n`=0, asynchronous) forces IDLE, mode = validate, counter 0, and all outputs 0 immediately, independent of `clk`.
- Leaving reset: the first edge with `rst_n`=1 samples the inputs.
- Training request sampled at edge 0 with default parameters:
  - `FPH` high cycles 1–8.
  - `FPO` cycles 9–40.
  - `BPO` cycles 41–44.
  - `BPH` cycles 45–48.
  - `S_Train` cycle 49.
  - IDLE cycle 50.
- Total training latency = 1 + L_FPH + L_FPO + L_BPO + L_BPH from request to `S_Train`.
- Validation latency = 1 + L_FPH + L_FPO from request to `S_Error` (cycle 41 with defaults).
- `S_Train`/`S_Error` are exactly one cycle wide.
- There are no gaps between phases: exactly one enable is high on every cycle from the first `FPH` through the last `BPH`.

## Test plan
- Reset mid-pass: assert `rst_n`=0 during `FPO` → all outputs 0 without waiting for a clock edge. Release and pulse `VL` → `FPH` rises one cycle after the sampling edge.
- Training, defaults: `TR`=1 for one cycle → `FPH` 8 cycles, `FPO` 32, `BPO` 4, `BPH` 4, then `S_Train` one cycle at cycle 49, back to IDLE. Never two flags high at once.
- Validation: `VL`=1 for one cycle → `FPH` 8 cycles, `FPO` 32, `S_Error` at cycle 41. `BPO`/`BPH`/`S_Train` never assert.
- Priority and held request:
  - `TR`=`VL`=1 → training sequence.
  - `TR` held high continuously → back-to-back passes with one idle cycle between `S_Train` and the next `FPH`.
  - `VL` toggled mid-pass → no effect.
- Abort: assert `END` during `BPO` → next cycle all outputs 0, no `S_Train`. Later `TR` pulses are ignored until reset.
- Parameter sweep: L_FPH=1, L_FPO=1, L_BPO=1, L_BPH=1 → one cycle per phase, `S_Train` 5 cycles after the sampling edge.
